// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: combinational rs/rt forwarding selection,
// load-use and MULT/DIV hazard stalls, a sequencer for the multicycle
// MULT/DIV unit that owns HI/LO, and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_muldiv_start,
  input  logic             id_reads_hilo,
  input  logic [4:0]       ex_dst,
  input  logic [4:0]       mem_dst,
  input  logic [4:0]       wb_dst,
  input  logic             ex_rf_en,
  input  logic             mem_rf_en,
  input  logic             wb_rf_en,
  input  logic             ex_load,
  input  logic             flush,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             idex_nop,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic             muldiv_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_count
);

  // Counter wide enough to hold MULDIV_CYCLES-1 (MULDIV_CYCLES >= 2).
  localparam int CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          lu, mh, stall;

  // Forwarding source for one operand: nearest producing stage wins; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] e_dst, input logic e_en,
    input logic [4:0] m_dst, input logic m_en,
    input logic [4:0] w_dst, input logic w_en
  );
    if (e_en && e_dst != 5'd0 && e_dst == src)      return 2'b01;
    else if (m_en && m_dst != 5'd0 && m_dst == src) return 2'b10;
    else if (w_en && w_dst != 5'd0 && w_dst == src) return 2'b11;
    else                                            return 2'b00;
  endfunction

  // Forwarding selects are purely combinational and stay valid through reset.
  always_comb begin
    fwd_rs = fwd_sel(id_rs, ex_dst, ex_rf_en, mem_dst, mem_rf_en, wb_dst, wb_rf_en);
    fwd_rt = fwd_sel(id_rt, ex_dst, ex_rf_en, mem_dst, mem_rf_en, wb_dst, wb_rf_en);
  end

  // Hazard detection; while reset is asserted nothing stalls.
  always_comb begin
    lu = ex_load && ex_rf_en && (ex_dst != 5'd0) &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    mh    = (id_reads_hilo || id_muldiv_start) && (state != IDLE);
    stall = (lu || mh) && !flush && reset_n;
  end

  // Pipeline register controls: flush beats stall and always injects a bubble.
  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    pc_ld    = 1'b1;
    ifid_ld  = 1'b1;
    idex_nop = 1'b0;
    if (reset_n) begin
      if (flush) begin
        idex_nop = 1'b1;
      end else if (stall) begin
        pc_ld    = 1'b0;
        ifid_ld  = 1'b0;
        idex_nop = 1'b1;
      end
    end
  end

  // MULT/DIV sequencer next-state: IDLE -> BUSY (MULDIV_CYCLES cycles) -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    count_next = count;
    hilo_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (id_muldiv_start && !stall && !flush) begin
          state_next = BUSY;
          count_next = CNT_LOAD;
        end
      end
      BUSY: begin
        if (count == '0) state_next = DONE;
        else             count_next = count - CW'(1);
      end
      DONE: begin
        hilo_we    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A flush abandons any operation in flight and suppresses its result.
    if (flush) begin
      state_next = IDLE;
      hilo_we    = 1'b0;
    end
  end

  assign muldiv_busy = (state != IDLE);

  // Sequencer state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against a
// behavioural model that tracks the MULT/DIV operation as "cycles since start".
module tb_pipeline_hazard_controller;

  localparam int N     = 4;   // MULDIV_CYCLES for both instances
  localparam int SAT_W = 3;   // narrow counter instance to exercise saturation

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst, wb_dst;
  logic       id_uses_rs, id_uses_rt, id_muldiv_start, id_reads_hilo;
  logic       ex_rf_en, mem_rf_en, wb_rf_en, ex_load, flush;

  logic        pc_ld, ifid_ld, idex_nop, muldiv_busy, hilo_we;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [31:0] stall_count;

  logic             s_pc_ld, s_ifid_ld, s_idex_nop, s_busy, s_hilo_we;
  logic [1:0]       s_fwd_rs, s_fwd_rt;
  logic [SAT_W-1:0] s_stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULDIV_CYCLES(N), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_muldiv_start(id_muldiv_start), .id_reads_hilo(id_reads_hilo),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
    .ex_load(ex_load), .flush(flush),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_nop(idex_nop),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .muldiv_busy(muldiv_busy), .hilo_we(hilo_we), .stall_count(stall_count)
  );

  pipeline_hazard_controller #(.MULDIV_CYCLES(N), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_muldiv_start(id_muldiv_start), .id_reads_hilo(id_reads_hilo),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
    .ex_load(ex_load), .flush(flush),
    .pc_ld(s_pc_ld), .ifid_ld(s_ifid_ld), .idex_nop(s_idex_nop),
    .fwd_rs(s_fwd_rs), .fwd_rt(s_fwd_rt),
    .muldiv_busy(s_busy), .hilo_we(s_hilo_we), .stall_count(s_stall_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase = cycles since the accepted start (0 = no operation). Busy while
  // 1..N+1, result written in phase N+1. mcount = unbounded stall count.
  int     phase  = 0;
  longint mcount = 0;

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (ex_rf_en && ex_dst != 0 && ex_dst == src)   return 2'd1;
    if (mem_rf_en && mem_dst != 0 && mem_dst == src) return 2'd2;
    if (wb_rf_en && wb_dst != 0 && wb_dst == src)   return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    logic lu, mh;
    lu = ex_load && ex_rf_en && ex_dst != 0 &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    mh = (id_reads_hilo || id_muldiv_start) && phase != 0;
    return (lu || mh) && !flush && reset_n;
  endfunction

  // Model state advance at the edge (inputs are stable here; they change 1 ns later).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  = 0;
      mcount = 0;
    end else begin
      logic st;
      st = m_stall();
      if (st) mcount = mcount + 1;
      if (flush)                                  phase = 0;
      else if (phase == 0)                        phase = (id_muldiv_start && !st) ? 1 : 0;
      else if (phase == N + 1)                    phase = 0;
      else                                        phase = phase + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic       st, nop;
    longint     sat_max;
    st      = m_stall();
    nop     = reset_n && (st || flush);
    sat_max = (longint'(1) << SAT_W) - 1;
    check("pc_ld",       32'(pc_ld),       32'(!st));
    check("ifid_ld",     32'(ifid_ld),     32'(!st));
    check("idex_nop",    32'(idex_nop),    32'(nop));
    check("fwd_rs",      32'(fwd_rs),      32'(m_fwd(id_rs)));
    check("fwd_rt",      32'(fwd_rt),      32'(m_fwd(id_rt)));
    check("muldiv_busy", 32'(muldiv_busy), 32'(phase != 0));
    check("hilo_we",     32'(hilo_we),     32'(phase == N + 1 && !flush));
    check("stall_count", stall_count,      32'(mcount));
    check("sat_count",   32'(s_stall_count), 32'((mcount > sat_max) ? sat_max : mcount));
    check("sat_pc_ld",   32'(s_pc_ld),     32'(!st));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_muldiv_start = 0; id_reads_hilo = 0;
    ex_dst = 0; mem_dst = 0; wb_dst = 0;
    ex_rf_en = 0; mem_rf_en = 0; wb_rf_en = 0; ex_load = 0; flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    tick();
    settle();
    // Reset state
    check("rst pc_ld",    32'(pc_ld), 32'd1);
    check("rst idex_nop", 32'(idex_nop), 32'd0);
    check("rst busy",     32'(muldiv_busy), 32'd0);
    check("rst count",    stall_count, 32'd0);
    id_rt = 5'd9; wb_dst = 5'd9; wb_rf_en = 1'b1;
    settle();
    check("rst fwd_rt valid", 32'(fwd_rt), 32'd3);
    do_reset();

    // 1: load-use stall of one cycle, then forward from MEM
    ex_load = 1; ex_dst = 8; ex_rf_en = 1; id_rs = 8; id_uses_rs = 1;
    settle();
    check("lu pc_ld",    32'(pc_ld), 32'd0);
    check("lu ifid_ld",  32'(ifid_ld), 32'd0);
    check("lu idex_nop", 32'(idex_nop), 32'd1);
    check("lu count0",   stall_count, 32'd0);
    tick();
    ex_load = 0; ex_rf_en = 0; ex_dst = 0; mem_dst = 8; mem_rf_en = 1;
    settle();
    check("lu fwd_rs mem", 32'(fwd_rs), 32'd2);
    check("lu released",   32'(pc_ld), 32'd1);
    check("lu count1",     stall_count, 32'd1);
    tick();

    // 2: forwarding priority
    clear_inputs();
    ex_dst = 9; mem_dst = 9; wb_dst = 9; ex_rf_en = 1; mem_rf_en = 1; wb_rf_en = 1; id_rt = 9;
    settle();
    check("prio ex", 32'(fwd_rt), 32'd1);
    ex_rf_en = 0;
    settle();
    check("prio mem", 32'(fwd_rt), 32'd2);
    ex_dst = 0; mem_dst = 0; wb_dst = 0; ex_rf_en = 1; id_rt = 0;
    settle();
    check("prio r0", 32'(fwd_rt), 32'd0);
    tick();

    // 3: MULT then MFHI with MULDIV_CYCLES=4
    do_reset();
    id_muldiv_start = 1;
    settle();
    check("md c0 accept", 32'(pc_ld), 32'd1);
    tick();
    for (int c = 1; c <= 5; c++) begin
      id_muldiv_start = 0; id_reads_hilo = 1;
      settle();
      check("md busy",  32'(muldiv_busy), 32'd1);
      check("md stall", 32'(pc_ld), 32'd0);
      check("md hilo_we", 32'(hilo_we), 32'(c == 5));
      tick();
    end
    settle();
    check("md c6 release", 32'(pc_ld), 32'd1);
    check("md c6 idle",    32'(muldiv_busy), 32'd0);
    check("md count5",     stall_count, 32'd5);
    tick();

    // 4: back-to-back start held in ID
    do_reset();
    id_muldiv_start = 1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      settle();
      check("b2b stalled", 32'(pc_ld), 32'd0);
      tick();
    end
    settle();
    check("b2b accepted", 32'(pc_ld), 32'd1);
    tick();
    id_muldiv_start = 0;
    settle();
    check("b2b busy again", 32'(muldiv_busy), 32'd1);
    tick();

    // 5: flush in 2nd BUSY cycle, then reset mid-BUSY
    do_reset();
    id_muldiv_start = 1;
    tick();
    id_muldiv_start = 0; id_reads_hilo = 1;
    tick();
    flush = 1;
    settle();
    check("fl pc_ld",    32'(pc_ld), 32'd1);
    check("fl idex_nop", 32'(idex_nop), 32'd1);
    tick();
    flush = 0;
    settle();
    check("fl idle",    32'(muldiv_busy), 32'd0);
    check("fl release", 32'(pc_ld), 32'd1);
    for (int c = 0; c < 6; c++) begin
      settle();
      check("fl no hilo_we", 32'(hilo_we), 32'd0);
      tick();
    end
    clear_inputs();
    id_muldiv_start = 1;
    tick();
    id_muldiv_start = 0; id_reads_hilo = 1;
    tick();
    reset_n = 0;
    settle();
    check("rst mid busy",  32'(muldiv_busy), 32'd0);
    check("rst mid count", stall_count, 32'd0);
    check("rst mid pc_ld", 32'(pc_ld), 32'd1);
    check("rst mid hilo",  32'(hilo_we), 32'd0);
    tick();
    do_reset();

    // 6: saturation of the narrow counter under a held stall
    ex_load = 1; ex_dst = 5; ex_rf_en = 1; id_rt = 5; id_uses_rt = 1;
    for (int c = 0; c < 9; c++) tick();
    settle();
    check("sat all-ones", 32'(s_stall_count), 32'd7);
    check("sat wide",     stall_count, 32'd9);
    tick();

    // Randomized traffic checked by the every-cycle model comparison
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_muldiv_start = ($urandom_range(0, 7) == 0);
      id_reads_hilo   = ($urandom_range(0, 3) == 0);
      ex_dst          = 5'($urandom_range(0, 3));
      mem_dst         = 5'($urandom_range(0, 3));
      wb_dst          = 5'($urandom_range(0, 3));
      ex_rf_en        = 1'($urandom_range(0, 1));
      mem_rf_en       = 1'($urandom_range(0, 1));
      wb_rf_en        = 1'($urandom_range(0, 1));
      ex_load         = ($urandom_range(0, 2) == 0);
      flush           = ($urandom_range(0, 15) == 0);
      reset_n         = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1;
    clear_inputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
